// File: rtl/cart_map_pkg.sv
// Shared definitions for the cartridge-mapper bus selector: FSM states,
// idle bus values and the channel numbering used by the SNES cart slot.
package cart_map_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_CONFLICT = 2'd3
  } map_state_e;

  // Values driven onto the shared ports while no channel owns them
  localparam logic [7:0] IDLE_DATA     = 8'h00;
  localparam logic       IDLE_IRQ_N    = 1'b1;
  localparam logic       IDLE_STROBE_N = 1'b1;
  localparam logic       IDLE_WORD     = 1'b0;

  // Channel numbering; channel 0 is the plain LoROM/HiROM/DSP fallback
  localparam int CH_DLH     = 0;
  localparam int CH_CX4     = 1;
  localparam int CH_SDD1    = 2;
  localparam int CH_GSU     = 3;
  localparam int CH_SA1     = 4;
  localparam int CH_SPC7110 = 5;

endpackage

// File: rtl/cart_map_sel_fsm.sv
// Channel-selection FSM: waits for map_active to stay stable for SETTLE_CYC
// cycles, then locks the requesting channel for the rest of the session.
// Multi-hot requests before lock are fatal until reset; changes after lock
// only raise the sticky change_err flag.
module cart_map_sel_fsm
  import cart_map_pkg::*;
#(
  parameter int NCH        = 6,
  parameter int SETTLE_CYC = 16,
  parameter int SEL_W      = $clog2(NCH)
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [NCH-2:0]   map_active,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             conflict,
  output logic             change_err
);

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SETTLE_CYC);

  map_state_e       state;
  map_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [NCH-2:0]   prev;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] hot_sel;
  logic             hot_seen;
  logic             multi_hot;
  logic             changed;
  logic             change_err_nxt;

  // Decode the request vector: bit k-1 selects channel k, none selects the fallback
  always_comb begin
    hot_seen  = 1'b0;
    multi_hot = 1'b0;
    hot_sel   = SEL_W'(CH_DLH);
    for (int k = 1; k < NCH; k++) begin
      if (map_active[k-1]) begin
        if (hot_seen) begin
          multi_hot = 1'b1;
        end
        hot_seen = 1'b1;
        hot_sel  = SEL_W'(k);
      end
    end
  end

  assign changed = (map_active != prev);

  // Next-state logic; HOLD behaves like SETTLE once reset is released so that
  // SETTLE_CYC=0 locks on the very first edge
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    change_err_nxt = change_err;
    case (state)
      ST_HOLD, ST_SETTLE: begin
        if (multi_hot) begin
          state_nxt = ST_CONFLICT;
          cnt_nxt   = '0;
        end else if (changed) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TERM) begin
          state_nxt = ST_LOCKED;
          sel_nxt   = hot_sel;
        end else begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (changed) begin
          change_err_nxt = 1'b1;
        end
      end
      ST_CONFLICT: begin
        state_nxt = ST_CONFLICT;
      end
      default: begin
        state_nxt = ST_HOLD;
      end
    endcase
  end

  // State, counter, locked selection, sticky flag and the request snapshot
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      cnt        <= '0;
      sel        <= '0;
      change_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      change_err <= change_err_nxt;
    end
    prev <= map_active;
  end

  assign locked   = (state == ST_LOCKED);
  assign conflict = (state == ST_CONFLICT);

endmodule

// File: rtl/cart_map_mux.sv
// Cartridge bus selector between the SNES core and NCH mapper channels.
// The locked channel's CPU, ROM and BSRAM signals are steered to the shared
// ports; unlocked ports sit at idle values. Defining CART_MAP_MUX_OUTREG_EN
// registers every data-path output, adding one mclk of latency.
module cart_map_mux
  import cart_map_pkg::*;
#(
  parameter int             NCH         = 6,
  parameter int             ROM_AW      = 24,
  parameter int             RAM_AW      = 20,
  parameter int             SETTLE_CYC  = 16,
  parameter logic [NCH-1:0] TURBO_BLOCK = 6'b001010
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic [NCH-2:0]           map_active,
  input  logic [NCH*8-1:0]         ch_do,
  input  logic [NCH-1:0]           ch_irq_n,
  input  logic [NCH*ROM_AW-1:0]    ch_rom_addr,
  input  logic [NCH-1:0]           ch_rom_ce_n,
  input  logic [NCH-1:0]           ch_rom_oe_n,
  input  logic [NCH-1:0]           ch_rom_word,
  input  logic [NCH*RAM_AW-1:0]    ch_bsram_addr,
  input  logic [NCH*8-1:0]         ch_bsram_d,
  input  logic [NCH-1:0]           ch_bsram_ce_n,
  input  logic [NCH-1:0]           ch_bsram_oe_n,
  input  logic [NCH-1:0]           ch_bsram_we_n,
  output logic [7:0]               di,
  output logic                     irq_n,
  output logic [ROM_AW-1:0]        rom_addr,
  output logic                     rom_ce_n,
  output logic                     rom_oe_n,
  output logic                     rom_word,
  output logic [RAM_AW-1:0]        bsram_addr,
  output logic [7:0]               bsram_d,
  output logic                     bsram_ce_n,
  output logic                     bsram_oe_n,
  output logic                     bsram_we_n,
  output logic [$clog2(NCH)-1:0]   sel,
  output logic                     locked,
  output logic                     conflict,
  output logic                     change_err,
  output logic                     turbo_allow
);

  localparam int SEL_W = $clog2(NCH);

  logic [7:0]        mux_di;
  logic              mux_irq_n;
  logic [ROM_AW-1:0] mux_rom_addr;
  logic              mux_rom_ce_n;
  logic              mux_rom_oe_n;
  logic              mux_rom_word;
  logic [RAM_AW-1:0] mux_bsram_addr;
  logic [7:0]        mux_bsram_d;
  logic              mux_bsram_ce_n;
  logic              mux_bsram_oe_n;
  logic              mux_bsram_we_n;
  logic              turbo_blocked;

  cart_map_sel_fsm #(
    .NCH        (NCH),
    .SETTLE_CYC (SETTLE_CYC),
    .SEL_W      (SEL_W)
  ) u_sel_fsm (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .map_active (map_active),
    .sel        (sel),
    .locked     (locked),
    .conflict   (conflict),
    .change_err (change_err)
  );

  // Steer the locked channel onto the shared ports and look up its turbo policy
  always_comb begin
    mux_di         = IDLE_DATA;
    mux_irq_n      = IDLE_IRQ_N;
    mux_rom_addr   = '0;
    mux_rom_ce_n   = IDLE_STROBE_N;
    mux_rom_oe_n   = IDLE_STROBE_N;
    mux_rom_word   = IDLE_WORD;
    mux_bsram_addr = '0;
    mux_bsram_d    = IDLE_DATA;
    mux_bsram_ce_n = IDLE_STROBE_N;
    mux_bsram_oe_n = IDLE_STROBE_N;
    mux_bsram_we_n = IDLE_STROBE_N;
    turbo_blocked  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SEL_W'(i)) begin
        turbo_blocked = TURBO_BLOCK[i];
        if (locked) begin
          mux_di         = ch_do[i*8 +: 8];
          mux_irq_n      = ch_irq_n[i];
          mux_rom_addr   = ch_rom_addr[i*ROM_AW +: ROM_AW];
          mux_rom_ce_n   = ch_rom_ce_n[i];
          mux_rom_oe_n   = ch_rom_oe_n[i];
          mux_rom_word   = ch_rom_word[i];
          mux_bsram_addr = ch_bsram_addr[i*RAM_AW +: RAM_AW];
          mux_bsram_d    = ch_bsram_d[i*8 +: 8];
          mux_bsram_ce_n = ch_bsram_ce_n[i];
          mux_bsram_oe_n = ch_bsram_oe_n[i];
          mux_bsram_we_n = ch_bsram_we_n[i];
        end
      end
    end
  end

  // Turbo is only granted once a channel is locked and it does not forbid it
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      turbo_allow <= 1'b0;
    end else begin
      turbo_allow <= locked & ~turbo_blocked;
    end
  end

`ifdef CART_MAP_MUX_OUTREG_EN
  // Registered data path; the mux is already idle while unlocked
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      di         <= IDLE_DATA;
      irq_n      <= IDLE_IRQ_N;
      rom_addr   <= '0;
      rom_ce_n   <= IDLE_STROBE_N;
      rom_oe_n   <= IDLE_STROBE_N;
      rom_word   <= IDLE_WORD;
      bsram_addr <= '0;
      bsram_d    <= IDLE_DATA;
      bsram_ce_n <= IDLE_STROBE_N;
      bsram_oe_n <= IDLE_STROBE_N;
      bsram_we_n <= IDLE_STROBE_N;
    end else begin
      di         <= mux_di;
      irq_n      <= mux_irq_n;
      rom_addr   <= mux_rom_addr;
      rom_ce_n   <= mux_rom_ce_n;
      rom_oe_n   <= mux_rom_oe_n;
      rom_word   <= mux_rom_word;
      bsram_addr <= mux_bsram_addr;
      bsram_d    <= mux_bsram_d;
      bsram_ce_n <= mux_bsram_ce_n;
      bsram_oe_n <= mux_bsram_oe_n;
      bsram_we_n <= mux_bsram_we_n;
    end
  end
`else
  assign di         = mux_di;
  assign irq_n      = mux_irq_n;
  assign rom_addr   = mux_rom_addr;
  assign rom_ce_n   = mux_rom_ce_n;
  assign rom_oe_n   = mux_rom_oe_n;
  assign rom_word   = mux_rom_word;
  assign bsram_addr = mux_bsram_addr;
  assign bsram_d    = mux_bsram_d;
  assign bsram_ce_n = mux_bsram_ce_n;
  assign bsram_oe_n = mux_bsram_oe_n;
  assign bsram_we_n = mux_bsram_we_n;
`endif

endmodule

// File: tb/tb_cart_map_mux.sv
// Self-checking bench for cart_map_mux: a request-history model predicts the
// selector outputs every cycle, and directed scenarios pin literal values.
// Honours CART_MAP_MUX_OUTREG_EN when the build defines it.
module tb_cart_map_mux;

  localparam int             NCH    = 6;
  localparam int             ROM_AW = 24;
  localparam int             RAM_AW = 20;
  localparam int             S      = 16;
  localparam logic [NCH-1:0] MASK   = 6'b001010;

  typedef struct packed {
    logic [7:0]        di;
    logic              irq_n;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_ce_n;
    logic              rom_oe_n;
    logic              rom_word;
    logic [RAM_AW-1:0] bsram_addr;
    logic [7:0]        bsram_d;
    logic              bsram_ce_n;
    logic              bsram_oe_n;
    logic              bsram_we_n;
  } bus_t;

  logic                  mclk = 1'b0;
  logic                  rst_n;
  logic [NCH-2:0]        map_active;
  logic [NCH*8-1:0]      ch_do;
  logic [NCH-1:0]        ch_irq_n;
  logic [NCH*ROM_AW-1:0] ch_rom_addr;
  logic [NCH-1:0]        ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
  logic [NCH*RAM_AW-1:0] ch_bsram_addr;
  logic [NCH*8-1:0]      ch_bsram_d;
  logic [NCH-1:0]        ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;

  logic [7:0]        di, z_di;
  logic              irq_n, z_irq_n;
  logic [ROM_AW-1:0] rom_addr, z_rom_addr;
  logic              rom_ce_n, rom_oe_n, rom_word, z_rom_ce_n, z_rom_oe_n, z_rom_word;
  logic [RAM_AW-1:0] bsram_addr, z_bsram_addr;
  logic [7:0]        bsram_d, z_bsram_d;
  logic              bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic              z_bsram_ce_n, z_bsram_oe_n, z_bsram_we_n;
  logic [2:0]        sel, z_sel;
  logic              locked, conflict, change_err, turbo_allow;
  logic              z_locked, z_conflict, z_change_err, z_turbo_allow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 mclk = ~mclk;

  cart_map_mux #(
    .NCH(NCH), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .SETTLE_CYC(S), .TURBO_BLOCK(MASK)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_word(rom_word), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
    .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
    .sel(sel), .locked(locked), .conflict(conflict), .change_err(change_err),
    .turbo_allow(turbo_allow)
  );

  // Second instance exercising the zero-settle boundary
  cart_map_mux #(
    .NCH(NCH), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .SETTLE_CYC(0), .TURBO_BLOCK(MASK)
  ) dut_z (
    .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(z_di), .irq_n(z_irq_n), .rom_addr(z_rom_addr), .rom_ce_n(z_rom_ce_n),
    .rom_oe_n(z_rom_oe_n), .rom_word(z_rom_word), .bsram_addr(z_bsram_addr),
    .bsram_d(z_bsram_d), .bsram_ce_n(z_bsram_ce_n), .bsram_oe_n(z_bsram_oe_n),
    .bsram_we_n(z_bsram_we_n), .sel(z_sel), .locked(z_locked), .conflict(z_conflict),
    .change_err(z_change_err), .turbo_allow(z_turbo_allow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit             m_valid = 0;
  bit             m_locked, m_conflict, m_cerr, m_turbo;
  int             m_sel;
  logic [NCH-2:0] hist[$];
  bus_t           m_reg;

  function automatic bus_t idle_bus();
    bus_t b;
    b = '0;
    b.irq_n = 1'b1;
    b.rom_ce_n = 1'b1;
    b.rom_oe_n = 1'b1;
    b.bsram_ce_n = 1'b1;
    b.bsram_oe_n = 1'b1;
    b.bsram_we_n = 1'b1;
    return b;
  endfunction

  function automatic bus_t pick(input int ch);
    bus_t b;
    b.di         = ch_do[ch*8 +: 8];
    b.irq_n      = ch_irq_n[ch];
    b.rom_addr   = ch_rom_addr[ch*ROM_AW +: ROM_AW];
    b.rom_ce_n   = ch_rom_ce_n[ch];
    b.rom_oe_n   = ch_rom_oe_n[ch];
    b.rom_word   = ch_rom_word[ch];
    b.bsram_addr = ch_bsram_addr[ch*RAM_AW +: RAM_AW];
    b.bsram_d    = ch_bsram_d[ch*8 +: 8];
    b.bsram_ce_n = ch_bsram_ce_n[ch];
    b.bsram_oe_n = ch_bsram_oe_n[ch];
    b.bsram_we_n = ch_bsram_we_n[ch];
    return b;
  endfunction

  function automatic bus_t model_bus();
    if (m_locked) return pick(m_sel);
    return idle_bus();
  endfunction

  function automatic bit hist_uniform();
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i] != hist[0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int owner(input logic [NCH-2:0] ma);
    int o;
    o = 0;
    for (int k = 0; k < NCH - 1; k++) begin
      if (ma[k]) o = k + 1;
    end
    return o;
  endfunction

  // Model: lock once the last S+1 samples (plus the reset-time sample) agree
  initial begin
    forever begin
      @(posedge mclk);
      if (!rst_n) begin
        hist.delete();
        hist.push_back(map_active);
        m_locked = 0; m_conflict = 0; m_cerr = 0; m_turbo = 0; m_sel = 0;
        m_reg = idle_bus();
        m_valid = 1;
      end else if (m_valid) begin
        m_reg = model_bus();
        m_turbo = m_locked && !MASK[m_sel];
        if (m_locked) begin
          if (map_active != hist[$]) m_cerr = 1;
          hist.delete();
          hist.push_back(map_active);
        end else if (!m_conflict) begin
          hist.push_back(map_active);
          if (hist.size() > S + 2) void'(hist.pop_front());
          if ($countones(map_active) > 1) begin
            m_conflict = 1;
          end else if (hist.size() == S + 2 && hist_uniform()) begin
            m_locked = 1;
            m_sel = owner(map_active);
          end
        end
      end
    end
  end

  // Compare every cycle against the model
  initial begin
    bus_t e;
    forever begin
      @(negedge mclk);
      if (m_valid) begin
`ifdef CART_MAP_MUX_OUTREG_EN
        e = m_reg;
`else
        e = model_bus();
`endif
        checkOutput("locked", locked, m_locked);
        checkOutput("conflict", conflict, m_conflict);
        checkOutput("change_err", change_err, m_cerr);
        checkOutput("sel", sel, m_sel);
        checkOutput("turbo_allow", turbo_allow, m_turbo);
        checkOutput("di", di, e.di);
        checkOutput("irq_n", irq_n, e.irq_n);
        checkOutput("rom_addr", rom_addr, e.rom_addr);
        checkOutput("rom_ctl", {rom_ce_n, rom_oe_n, rom_word}, {e.rom_ce_n, e.rom_oe_n, e.rom_word});
        checkOutput("bsram_addr", bsram_addr, e.bsram_addr);
        checkOutput("bsram_d", bsram_d, e.bsram_d);
        checkOutput("bsram_ctl", {bsram_ce_n, bsram_oe_n, bsram_we_n},
                    {e.bsram_ce_n, e.bsram_oe_n, e.bsram_we_n});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic applyReset(input int cycles, input logic [NCH-2:0] ma);
    @(negedge mclk);
    #1;
    rst_n = 1'b0;
    map_active = ma;
    repeat (cycles) @(negedge mclk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [NCH-2:0] ma);
    #1;
    map_active = ma;
  endtask

  initial begin
    rst_n = 1'b0;
    map_active = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_do[i*8 +: 8]                 = 8'(8'h30 + i);
      ch_rom_addr[i*ROM_AW +: ROM_AW] = 24'(24'h010101 * (i + 1));
      ch_bsram_addr[i*RAM_AW +: RAM_AW] = 20'(20'h01357 * (i + 1));
      ch_bsram_d[i*8 +: 8]            = 8'(8'hC0 + i);
    end
    ch_do[4*8 +: 8]      = 8'hA5;
    ch_rom_addr[23:0]    = 24'h123456;
    ch_irq_n      = 6'b000000;
    ch_rom_ce_n   = 6'b000000;
    ch_rom_oe_n   = 6'b101010;
    ch_rom_word   = 6'b110101;
    ch_bsram_ce_n = 6'b000000;
    ch_bsram_oe_n = 6'b011001;
    ch_bsram_we_n = 6'b100110;

    // Stable zero-hot request locks the fallback at edge 17
    applyReset(2, 5'b00000);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_rom_ce_n", rom_ce_n, 1);
    tick(1);
    checkOutput("z_lock_edge1", z_locked, 1);
    checkOutput("z_sel_edge1", z_sel, 0);
    checkOutput("settle_not_yet", locked, 0);
    tick(15);
    checkOutput("edge16_unlocked", locked, 0);
    tick(1);
    checkOutput("edge17_locked", locked, 1);
    checkOutput("edge17_sel", sel, 0);
    checkOutput("turbo_lag", turbo_allow, 0);
`ifndef CART_MAP_MUX_OUTREG_EN
    checkOutput("ch0_rom_addr", rom_addr, 24'h123456);
`endif
    tick(1);
    checkOutput("ch0_turbo", turbo_allow, 1);
    checkOutput("ch0_rom_addr_late", rom_addr, 24'h123456);
    #1 ch_rom_ce_n[0] = 1'b1;
    tick(1);
    checkOutput("ch0_ce_high", rom_ce_n, 1);
    #1 ch_rom_ce_n[0] = 1'b0;
    #1;
`ifdef CART_MAP_MUX_OUTREG_EN
    checkOutput("outreg_ce_hold", rom_ce_n, 1);
`else
    checkOutput("comb_ce_now", rom_ce_n, 0);
`endif
    tick(1);
    checkOutput("ce_after_edge", rom_ce_n, 0);

    // SA1 request: sel=4, data passes, turbo granted one cycle after lock
    applyReset(2, 5'b01000);
    tick(17);
    checkOutput("sa1_locked", locked, 1);
    checkOutput("sa1_sel", sel, 4);
    checkOutput("sa1_turbo_lag", turbo_allow, 0);
    checkOutput("z_sa1_sel", z_sel, 4);
    tick(1);
    checkOutput("sa1_di", di, 8'hA5);
    checkOutput("sa1_turbo", turbo_allow, 1);

    // Multi-hot request: conflict until reset, outputs idle
    applyReset(2, 5'b00101);
    tick(1);
    checkOutput("conflict_set", conflict, 1);
    checkOutput("z_conflict_set", z_conflict, 1);
    tick(20);
    checkOutput("conflict_sticky", conflict, 1);
    checkOutput("conflict_unlocked", locked, 0);
    checkOutput("conflict_rom_ce_n", rom_ce_n, 1);
    checkOutput("conflict_irq_n", irq_n, 1);
    checkOutput("conflict_di", di, 8'h00);
    applyReset(1, 5'b00000);
    checkOutput("conflict_cleared", conflict, 0);

    // Change at settle count 10 restarts the count: lock moves to edge 28
    tick(10);
    checkOutput("pre_toggle", locked, 0);
    applyStimulus(5'b00001);
    tick(1);
    checkOutput("z_change_err", z_change_err, 1);
    checkOutput("z_sel_kept", z_sel, 0);
    tick(16);
    checkOutput("edge27_unlocked", locked, 0);
    tick(1);
    checkOutput("edge28_locked", locked, 1);
    checkOutput("edge28_sel", sel, 1);
    tick(1);
    checkOutput("cx4_turbo_blocked", turbo_allow, 0);

    // GSU lock, late change, reset and relock to CX4
    applyReset(2, 5'b00100);
    tick(17);
    checkOutput("gsu_locked", locked, 1);
    checkOutput("gsu_sel", sel, 3);
    tick(1);
    checkOutput("gsu_turbo", turbo_allow, 0);
    checkOutput("gsu_no_err", change_err, 0);
    applyStimulus(5'b00001);
    tick(1);
    checkOutput("late_change_err", change_err, 1);
    checkOutput("late_sel_frozen", sel, 3);
    checkOutput("late_still_locked", locked, 1);
    applyReset(1, 5'b00001);
    checkOutput("rst_clears_err", change_err, 0);
    checkOutput("rst_clears_lock", locked, 0);
    checkOutput("rst_clears_sel", sel, 0);
    tick(17);
    checkOutput("relock", locked, 1);
    checkOutput("relock_sel", sel, 1);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
